// File: rtl/key_pulser_pkg.sv
// Shared definitions for the key pulser: channel FSM encoding, key bit indices
// and the counter-width helper.
package key_pulser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PRESS_DB    = 3'd1,
        ST_HELD_DELAY  = 3'd2,
        ST_HELD_REPEAT = 3'd3,
        ST_RELEASE_DB  = 3'd4
    } ch_state_e;

    localparam int KEY_LEFT  = 3;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_RIGHT = 0;

    // One width serves every counter so each can hold the largest timing parameter.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// Single pushbutton channel: 2-flop synchronizer, debounce/auto-repeat FSM and
// a registered one-cycle pulse output.
module key_channel
    import key_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_pulse
);

    localparam logic [CNT_W-1:0] DB_C    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    logic             r_sync1, r_sync2;
    ch_state_e        r_state, w_nxt;
    logic [CNT_W-1:0] r_dcnt, r_rcnt;
    logic [CNT_W-1:0] w_dcnt_inc, w_rcnt_inc;
    logic             r_pulse, w_fire;
    logic             w_pressed;

    assign w_pressed  = ~r_sync2;
    assign w_dcnt_inc = (r_dcnt == '1) ? r_dcnt : r_dcnt + 1'b1;
    assign w_rcnt_inc = (r_rcnt == '1) ? r_rcnt : r_rcnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:        if (w_pressed) w_nxt = ST_PRESS_DB;
            ST_PRESS_DB:    if (!w_pressed) w_nxt = ST_IDLE;
                            else if (r_dcnt >= DB_C) w_nxt = ST_HELD_DELAY;
            ST_HELD_DELAY:  if (!w_pressed) w_nxt = ST_RELEASE_DB;
                            else if (r_rcnt >= RD_LAST) w_nxt = ST_HELD_REPEAT;
            ST_HELD_REPEAT: if (!w_pressed) w_nxt = ST_RELEASE_DB;
            ST_RELEASE_DB:  if (w_pressed) w_nxt = ST_HELD_REPEAT;
                            else if (r_dcnt >= DB_C) w_nxt = ST_IDLE;
            default:        w_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_fire = 1'b0;
        if (w_pressed) begin
            case (r_state)
                ST_PRESS_DB:    w_fire = (r_dcnt >= DB_C);
                ST_HELD_DELAY:  w_fire = (r_rcnt >= RD_LAST);
                ST_HELD_REPEAT: w_fire = (r_rcnt >= RR_LAST);
                default:        w_fire = 1'b0;
            endcase
        end
    end

    // Repeat counter restarts on every pulse so the next one lands a full period later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dcnt  <= '0;
            r_rcnt  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_fire;
            case (r_state)
                ST_IDLE: begin
                    r_dcnt <= w_pressed ? CNT_W'(1) : '0;
                    r_rcnt <= '0;
                end
                ST_PRESS_DB: begin
                    r_rcnt <= '0;
                    if (!w_pressed || w_fire) r_dcnt <= '0;
                    else                      r_dcnt <= w_dcnt_inc;
                end
                ST_HELD_DELAY, ST_HELD_REPEAT: begin
                    if (!w_pressed) begin
                        r_dcnt <= CNT_W'(1);
                        r_rcnt <= '0;
                    end else begin
                        r_dcnt <= '0;
                        r_rcnt <= w_fire ? '0 : w_rcnt_inc;
                    end
                end
                ST_RELEASE_DB: begin
                    r_rcnt <= '0;
                    if (w_pressed || r_dcnt >= DB_C) r_dcnt <= '0;
                    else                             r_dcnt <= w_dcnt_inc;
                end
                default: begin
                    r_dcnt <= '0;
                    r_rcnt <= '0;
                end
            endcase
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/key_pulser.sv
// Four debounced auto-repeat key channels with opposing-direction suppression,
// enable gating and a registered active-high pulse output.
module key_pulser
    import key_pulser_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [3:0] i_KEY_N,
    output logic [3:0] o_KEY
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

    logic [3:0] w_pulse;
    logic [3:0] w_masked;
    logic [3:0] r_key;

    key_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE),
        .CNT_W           (CNT_W)
    ) u_ch [3:0] (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_key_n (i_KEY_N),
        .o_pulse (w_pulse)
    );

    // Simultaneous opposing moves cancel; the orthogonal pair passes untouched.
    always_comb begin
        w_masked = w_pulse;
        if (w_pulse[KEY_LEFT] && w_pulse[KEY_RIGHT]) begin
            w_masked[KEY_LEFT]  = 1'b0;
            w_masked[KEY_RIGHT] = 1'b0;
        end
        if (w_pulse[KEY_UP] && w_pulse[KEY_DOWN]) begin
            w_masked[KEY_UP]   = 1'b0;
            w_masked[KEY_DOWN] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_key <= 4'b0000;
        else          r_key <= i_enable ? w_masked : 4'b0000;
    end

    assign o_KEY = r_key;

endmodule

// File: tb/tb_key_pulser.sv
// Bench for key_pulser: directed timing scenarios plus randomized key activity
// compared every cycle against an event-time reference model.
module tb_key_pulser;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key;

    int n_chk = 0;
    int n_fail = 0;

    key_pulser #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (enable),
        .i_KEY_N  (key_n),
        .o_KEY    (key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: per key a mode plus absolute event times (press start,
    // release start, next due pulse) measured in clock edges.
    int         m_mode [4];
    int         m_t0   [4];
    int         m_next [4];
    logic [3:0] m_pend;
    logic [3:0] m_key;
    logic [3:0] m_raw_q[$];
    int         mcyc = 0;

    function automatic logic [3:0] resolve(input logic [3:0] p);
        logic [3:0] r;
        r = p;
        if (p[3] && p[0]) begin r[3] = 1'b0; r[0] = 1'b0; end
        if (p[2] && p[1]) begin r[2] = 1'b0; r[1] = 1'b0; end
        return r;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) m_mode[c] = 0;
        m_pend  = 4'b0;
        m_key   = 4'b0;
        m_raw_q = {4'hF, 4'hF};
    endfunction

    function automatic void model_edge(input logic [3:0] kn, input logic en, input logic rn);
        logic [3:0] s, newp;
        if (!rn) begin
            model_reset();
            return;
        end
        m_key = en ? resolve(m_pend) : 4'b0;
        s = m_raw_q.pop_front();   // raw level seen two edges earlier
        m_raw_q.push_back(kn);
        newp = 4'b0;
        for (int c = 0; c < 4; c++) begin
            case (m_mode[c])
                0: if (!s[c]) begin m_mode[c] = 1; m_t0[c] = mcyc; end
                1: if (s[c]) m_mode[c] = 0;
                   else if (mcyc - m_t0[c] == DB) begin
                       m_mode[c] = 2; newp[c] = 1'b1; m_next[c] = mcyc + RD;
                   end
                2: if (s[c]) begin m_mode[c] = 3; m_t0[c] = mcyc; end
                   else if (mcyc == m_next[c]) begin
                       newp[c] = 1'b1; m_next[c] = mcyc + RR;
                   end
                default: if (!s[c]) begin m_mode[c] = 2; m_next[c] = mcyc + RR; end
                         else if (mcyc - m_t0[c] == DB) m_mode[c] = 0;
            endcase
        end
        m_pend = newp;
        mcyc++;
    endfunction

    task automatic tick(input logic [3:0] kn, input logic en, input logic rn);
        key_n  = kn;
        enable = en;
        rst_n  = rn;
        @(posedge clk);
        model_edge(kn, en, rn);
        #1;
        chk("model", {60'b0, key}, {60'b0, m_key});
    endtask

    logic [63:0] obs [4];

    // Relative cycle k = k-th edge after the scenario starts; keys in 'press'
    // are held for edges 0..hold-1.
    task automatic scen(input logic [3:0] press, input int hold, input int n,
                        input int en_until, input int rst_at, input bit do_rst);
        if (do_rst) begin
            tick(4'hF, 1'b1, 1'b0);
            chk("rst_key", {60'b0, key}, 64'd0);
        end
        for (int b = 0; b < 4; b++) obs[b] = '0;
        for (int k = 0; k < n; k++) begin
            tick((k < hold) ? ~press : 4'hF, (k > en_until), (k != rst_at));
            if (k == rst_at) chk("rst_mid", {60'b0, key}, 64'd0);
            for (int b = 0; b < 4; b++) obs[b][k] = key[b];
        end
    endtask

    initial begin
        int         hold_left [4];
        logic [3:0] raw;
        model_reset();

        tick(4'hF, 1'b1, 1'b0);
        chk("reset_state", {60'b0, key}, 64'd0);

        scen(4'b0001, 8, 40, -1, -1, 1'b1);
        chk("single_k0", obs[0], 64'd1 << 7);
        chk("single_oth", obs[1] | obs[2] | obs[3], 64'd0);

        scen(4'b0100, 29, 45, -1, -1, 1'b1);
        chk("repeat_k2", obs[2], (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 20) |
                                 (64'd1 << 23) | (64'd1 << 26) | (64'd1 << 29));

        scen(4'b0010, 2, 30, -1, -1, 1'b1);
        chk("bounce_k1", obs[1], 64'd0);
        scen(4'b0010, 8, 30, -1, -1, 1'b0);
        chk("after_bounce", obs[1], 64'd1 << 7);

        scen(4'b1101, 12, 30, -1, -1, 1'b1);
        chk("conf_left", obs[3], 64'd0);
        chk("conf_right", obs[0], 64'd0);
        chk("conf_up", obs[2], 64'd1 << 7);

        scen(4'b0001, 16, 40, -1, 5, 1'b1);
        chk("rst_repress", obs[0], 64'd1 << 13);

        scen(4'b0010, 22, 40, 20, -1, 1'b1);
        chk("enable_gate", obs[1], 64'd1 << 23);

        // Random key activity mixing bounces, long holds, enable drops and resets.
        tick(4'hF, 1'b1, 1'b0);
        raw = 4'hF;
        for (int c = 0; c < 4; c++) hold_left[c] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold_left[c] == 0) begin
                    raw[c] = ~raw[c];
                    hold_left[c] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3)
                                                              : $urandom_range(5, 40);
                end else begin
                    hold_left[c]--;
                end
            end
            tick(raw, ($urandom_range(0, 15) != 0), ($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
